// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receive and transmit ends.
//   uart_state_e     : receiver FSM state encoding
//   UART_DATA_BITS   : data bits per frame
//   even_parity()    : parity bit that makes the data plus parity bit even
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync -- two-flop synchroniser for the asynchronous serial line.
// The output resets to 1 so that reset does not look like a start bit.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   d_i   : asynchronous input
//   q_o   : synchronised output
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- UART receiver: start bit, 8 data bits LSB first, optional even
// parity bit, one stop bit. Bits are sampled mid-bit using a clock-counted
// baud interval of CLKS_PER_BIT cycles (even, >= 4).
// Build option: define UART_RX_PARITY_EN to include and check the parity bit;
// otherwise the frame is 10 bits and parity_error is tied to 0.
// Ports:
//   clk          : system clock, rising edge
//   reset        : asynchronous active-high reset
//   rx           : serial input, idle high, asynchronous
//   data_out     : last received byte
//   data_valid   : one-cycle strobe when data_out/flags update
//   parity_error : parity mismatch on the last frame
//   frame_error  : stop bit sampled low on the last frame
//   rx_busy      : frame in progress
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

  uart_state_e               state_q;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [BW-1:0]             bit_q;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]                data_q;
  logic                      dv_q;
  logic                      ferr_q;
  logic                      rx_s;
  logic                      data_sample;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  assign cnt_d       = cnt_q + CW'(1);
  assign data_sample = (state_q == ST_DATA) && (cnt_q == FULL_CNT);
  assign shift_d     = {rx_s, shift_q[UART_DATA_BITS-1:1]};

  // Shift register is pure data: no reset, loaded only at data sample points.
  always_ff @(posedge clk) begin
    if (data_sample) shift_q <= shift_d;
  end

`ifdef UART_RX_PARITY_EN
  logic perr_q;
  logic perr_pend_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q      <= 1'b0;
      perr_pend_q <= 1'b0;
`endif
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          bit_q <= '0;
          if (!rx_s) state_q <= ST_START;
        end
        // Half-bit wait re-checks the start bit; a high sample is a glitch.
        ST_START: begin
          if (cnt_q == HALF_CNT) begin
            cnt_q   <= '0;
            state_q <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DATA: begin
          if (cnt_q == FULL_CNT) begin
            cnt_q <= '0;
            bit_q <= bit_q + BW'(1);
`ifdef UART_RX_PARITY_EN
            if (bit_q == LAST_BIT) state_q <= ST_PARITY;
`else
            if (bit_q == LAST_BIT) state_q <= ST_STOP;
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_q == FULL_CNT) begin
            cnt_q       <= '0;
            perr_pend_q <= (rx_s != even_parity(shift_q));
            state_q     <= ST_STOP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
`endif
        // Outputs load at the stop sample, so the strobe cycle is already
        // IDLE and a start bit right after the stop bit is not missed.
        ST_STOP: begin
          if (cnt_q == FULL_CNT) begin
            cnt_q   <= '0;
            data_q  <= shift_q;
            dv_q    <= 1'b1;
            ferr_q  <= ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_pend_q;
`endif
            state_q <= rx_s ? ST_IDLE : ST_BREAK;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        // Line held low past the stop bit: wait for it to return high.
        ST_BREAK: begin
          if (rx_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_out    = data_q;
  assign data_valid  = dv_q;
  assign frame_error = ferr_q;
  assign rx_busy     = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_error = perr_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME_BITS = PAR_EN ? 11 : 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       frame_error;
  logic       rx_busy;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .rx_busy      (rx_busy)
  );

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         cyc;
  } strobe_t;

  typedef struct {
    logic [7:0] d;
    bit         flip;
    bit         stop;
    logic [7:0] exp_d;
    bit         exp_pe;
    bit         exp_fe;
  } vec_t;

  strobe_t q[$];
  int      cyc = 0;
  int      wide = 0;
  bit      busy_seen = 1'b0;
  int      n_cmp = 0;
  int      n_mis = 0;
  logic    last_pe = 1'b0;
  logic    last_fe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampling away from the active edge.
  initial begin
    logic dv_prev;
    strobe_t s;
    dv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        s.d = data_out; s.pe = parity_error; s.fe = frame_error; s.cyc = cyc;
        q.push_back(s);
        if (dv_prev) wide++;
      end
      dv_prev = (data_valid === 1'b1);
      if (rx_busy === 1'b1) busy_seen = 1'b1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit((^d) ^ flip);
    drive_bit(stop);
  endtask

  task automatic expect_frame(input string nm, input logic [7:0] ed, input logic epe,
                              input logic efe, output int scyc);
    strobe_t s;
    int i;
    i = 0;
    scyc = -1;
    while (q.size() == 0 && i < 64) begin
      @(posedge clk);
      i++;
    end
    check({nm, " strobe count"}, q.size(), 1);
    if (q.size() != 0) begin
      s = q.pop_front();
      scyc = s.cyc;
      check({nm, " data"}, s.d, ed);
      check({nm, " parity_error"}, s.pe, epe);
      check({nm, " frame_error"}, s.fe, efe);
      last_pe = epe;
      last_fe = efe;
    end
    q.delete();
  endtask

  // Sends a frame; a low stop bit is followed by a low hold before the line
  // returns high. Expected values come from the frame contents.
  task automatic run_frame(input string nm, input logic [7:0] d, input bit flip,
                           input bit stop, input int hold, input logic [7:0] ed,
                           input logic epe, input logic efe);
    int sc;
    send_frame(d, flip, stop);
    if (!stop) begin
      repeat (hold) @(negedge clk);
      rx = 1'b1;
      repeat (4) @(negedge clk);
    end
    expect_frame(nm, ed, epe, efe, sc);
    @(negedge clk);
    check({nm, " busy after"}, rx_busy, 1'b0);
  endtask

  initial begin
    vec_t vecs[4];
    int   c0, c1;
    logic [7:0] rd;
    bit   rflip, rstop;

    vecs[0] = '{8'hA4, 1'b0, 1'b1, 8'hA4, 1'b0,   1'b0};
    vecs[1] = '{8'h62, 1'b1, 1'b1, 8'h62, PAR_EN, 1'b0};
    vecs[2] = '{8'h55, 1'b0, 1'b0, 8'h55, 1'b0,   1'b1};
    vecs[3] = '{8'h0F, 1'b0, 1'b1, 8'h0F, 1'b0,   1'b0};

    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset data_out", data_out, 8'h00);
    check("reset data_valid", data_valid, 1'b0);
    check("reset parity_error", parity_error, 1'b0);
    check("reset frame_error", frame_error, 1'b0);
    check("reset rx_busy", rx_busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Table: good frame, bad parity, stop low held 100 cycles, clean frame.
    for (int i = 0; i < 4; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].flip, vecs[i].stop, 100,
                vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe);

    // False start: short low pulse.
    busy_seen = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("false start strobes", q.size(), 0);
    check("false start busy pulse", busy_seen, 1'b1);
    check("false start busy end", rx_busy, 1'b0);
    check("false start data held", data_out, 8'h0F);
    check("false start pe held", parity_error, last_pe);
    check("false start fe held", frame_error, last_fe);
    q.delete();

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    begin
      strobe_t s0, s1;
      int i;
      i = 0;
      while (q.size() < 2 && i < 64) begin @(posedge clk); i++; end
      check("b2b strobe count", q.size(), 2);
      if (q.size() >= 2) begin
        s0 = q.pop_front();
        s1 = q.pop_front();
        check("b2b data0", s0.d, 8'h00);
        check("b2b data1", s1.d, 8'hFF);
        check("b2b errors0", {s0.pe, s0.fe}, 2'b00);
        check("b2b errors1", {s1.pe, s1.fe}, 2'b00);
        c0 = s0.cyc;
        c1 = s1.cyc;
        check("b2b spacing", c1 - c0, FRAME_BITS * CPB);
      end
      q.delete();
    end
    repeat (5) @(negedge clk);

    // Reset during the 4th data bit.
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    check("pre-reset busy", rx_busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mid reset data_out", data_out, 8'h00);
    check("mid reset data_valid", data_valid, 1'b0);
    check("mid reset flags", {parity_error, frame_error}, 2'b00);
    check("mid reset rx_busy", rx_busy, 1'b0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("mid reset no strobe", q.size(), 0);
    run_frame("after reset", 8'hC3, 1'b0, 1'b1, 0, 8'hC3, 1'b0, 1'b0);

    // Randomised frames against the frame-level model.
    for (int n = 0; n < 20; n++) begin
      rd    = 8'($urandom);
      rflip = ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 5) != 0);
      run_frame($sformatf("rand%0d", n), rd, rflip, rstop, $urandom_range(2, 40),
                rd, PAR_EN & rflip, ~rstop);
      check($sformatf("rand%0d data held", n), data_out, rd);
      repeat (4 + $urandom_range(0, 12)) @(negedge clk);
    end

    check("strobe width", wide, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
